// File: rtl/cam_pkg.sv
// cam_pkg: shared helpers for the parametrised CAM.
package cam_pkg;
  function automatic int cam_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/param_cam_if.sv
// param_cam_if: write/invalidate/read/search/free bus of param_cam.
// search_mask_i exists only when CAM_TERNARY_EN is defined.
interface param_cam_if
  import cam_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
);
  localparam int IDX_W = cam_idx_w(DEPTH);
  logic             write_enable_i;
  logic [IDX_W-1:0] write_index_i;
  logic [WIDTH-1:0] write_data_i;
  logic             invalidate_i;
  logic [IDX_W-1:0] invalidate_index_i;
  logic [IDX_W-1:0] read_index_i;
  logic [WIDTH-1:0] read_value_o;
  logic             read_valid_o;
  logic             search_enable_i;
  logic [WIDTH-1:0] search_data_i;
`ifdef CAM_TERNARY_EN
  logic [WIDTH-1:0] search_mask_i;
`endif
  logic             search_valid_o;
  logic             search_hit_o;
  logic [IDX_W-1:0] search_index_o;
  logic             search_multi_o;
  logic             free_valid_o;
  logic [IDX_W-1:0] free_index_o;
  modport master (
    output write_enable_i, write_index_i, write_data_i,
    output invalidate_i, invalidate_index_i, read_index_i,
    output search_enable_i, search_data_i,
`ifdef CAM_TERNARY_EN
    output search_mask_i,
`endif
    input  read_value_o, read_valid_o,
    input  search_valid_o, search_hit_o, search_index_o, search_multi_o,
    input  free_valid_o, free_index_o
  );
  modport slave (
    input  write_enable_i, write_index_i, write_data_i,
    input  invalidate_i, invalidate_index_i, read_index_i,
    input  search_enable_i, search_data_i,
`ifdef CAM_TERNARY_EN
    input  search_mask_i,
`endif
    output read_value_o, read_valid_o,
    output search_valid_o, search_hit_o, search_index_o, search_multi_o,
    output free_valid_o, free_index_o
  );
endinterface

// File: rtl/cam_prio_enc.sv
// cam_prio_enc: lowest-set-bit encoder with any-set and more-than-one-set flags.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]            vec,
  output logic [cam_idx_w(N)-1:0] idx,
  output logic                    any,
  output logic                    multi
);
  localparam int IW = cam_idx_w(N);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vec[i]) idx = i[IW-1:0];
  end
  assign any   = |vec;
  assign multi = |(vec & (vec - N'(1)));
endmodule

// File: rtl/param_cam.sv
// param_cam: DEPTH x WIDTH CAM with 2-stage search, registered read and free-entry allocator.
// Define CAM_TERNARY_EN to add a per-search don't-care mask.
module param_cam
  import cam_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  param_cam_if.slave bus
);
  localparam int IDX_W = cam_idx_w(DEPTH);
  typedef struct packed {
    logic             valid;
    logic [DEPTH-1:0] match;
  } s1_t;
  typedef struct packed {
    logic             valid;
    logic             hit;
    logic             multi;
    logic [IDX_W-1:0] index;
  } res_t;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid, match;
  logic [WIDTH-1:0] care, read_value;
  logic             read_valid;
  s1_t              s1;
  res_t             res;
  logic [IDX_W-1:0] hit_idx, free_idx;
  logic             hit_any, hit_multi, free_any, free_multi_unused;
`ifdef CAM_TERNARY_EN
  assign care = ~bus.search_mask_i;
`else
  assign care = '1;
`endif
  always_comb begin
    match = '0;
    for (int k = 0; k < DEPTH; k++)
      match[k] = valid[k] && (((mem[k] ^ bus.search_data_i) & care) == '0);
  end
  always_ff @(posedge clk_i)
    if (bus.write_enable_i) mem[bus.write_index_i] <= bus.write_data_i;
  // Write is applied after invalidate so it wins on a same-index collision.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid      <= '0;
      read_value <= '0;
      read_valid <= 1'b0;
      s1         <= '0;
      res        <= '0;
    end else begin
      if (bus.invalidate_i) valid[bus.invalidate_index_i] <= 1'b0;
      if (bus.write_enable_i) valid[bus.write_index_i] <= 1'b1;
      read_value <= mem[bus.read_index_i];
      read_valid <= valid[bus.read_index_i];
      s1         <= '{valid: bus.search_enable_i, match: match};
      res        <= s1.valid ? '{valid: 1'b1, hit: hit_any, multi: hit_multi, index: hit_idx} : '0;
    end
  end
  cam_prio_enc #(.N(DEPTH)) u_hit_enc (
    .vec   (s1.match),
    .idx   (hit_idx),
    .any   (hit_any),
    .multi (hit_multi)
  );
  cam_prio_enc #(.N(DEPTH)) u_free_enc (
    .vec   (~valid),
    .idx   (free_idx),
    .any   (free_any),
    .multi (free_multi_unused)
  );
  assign bus.read_value_o   = read_value;
  assign bus.read_valid_o   = read_valid;
  assign bus.search_valid_o = res.valid;
  assign bus.search_hit_o   = res.hit;
  assign bus.search_index_o = res.index;
  assign bus.search_multi_o = res.multi;
  assign bus.free_valid_o   = free_any;
  assign bus.free_index_o   = free_idx;
endmodule

// File: tb/tb_param_cam.sv
// tb_param_cam: directed self-checking bench for param_cam (DEPTH=32, WIDTH=32).
module tb_param_cam;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] bb_key [4] = '{32'h11, 32'h22, 32'h99, 32'h44};
  logic        bb_hit [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [4:0]  bb_idx [4] = '{5'd1, 5'd2, 5'd0, 5'd4};
  always #5 clk_i = ~clk_i;
  param_cam_if #(.DEPTH(32), .WIDTH(32)) bus ();
  param_cam #(.DEPTH(32), .WIDTH(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic idle;
    bus.write_enable_i  = 1'b0;
    bus.invalidate_i    = 1'b0;
    bus.search_enable_i = 1'b0;
  endtask
  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    bus.write_enable_i = 1'b1;
    bus.write_index_i  = idx;
    bus.write_data_i   = d;
    tick;
    bus.write_enable_i = 1'b0;
  endtask
  task automatic inv(input logic [4:0] idx);
    bus.invalidate_i       = 1'b1;
    bus.invalidate_index_i = idx;
    tick;
    bus.invalidate_i = 1'b0;
  endtask
  task automatic srch(input string tag, input logic [31:0] key, input logic hit,
                      input logic [4:0] idx, input logic multi);
    bus.search_enable_i = 1'b1;
    bus.search_data_i   = key;
    tick;
    bus.search_enable_i = 1'b0;
    tick;
    check({tag, "_valid"}, 32'(bus.search_valid_o), 32'd1);
    check({tag, "_hit"}, 32'(bus.search_hit_o), 32'(hit));
    check({tag, "_index"}, 32'(bus.search_index_o), 32'(idx));
    check({tag, "_multi"}, 32'(bus.search_multi_o), 32'(multi));
  endtask
  initial begin
    idle;
    bus.write_index_i      = '0;
    bus.write_data_i       = '0;
    bus.invalidate_index_i = '0;
    bus.read_index_i       = '0;
    bus.search_data_i      = '0;
`ifdef CAM_TERNARY_EN
    bus.search_mask_i = '0;
`endif
    #12;
    check("rst_free_valid", 32'(bus.free_valid_o), 32'd1);
    check("rst_free_index", 32'(bus.free_index_o), 32'd0);
    check("rst_search_valid", 32'(bus.search_valid_o), 32'd0);
    check("rst_read_valid", 32'(bus.read_valid_o), 32'd0);
    check("rst_read_value", bus.read_value_o, 32'd0);
    rst_i = 1'b1;
    bus.read_index_i = 5'd5;
    tick;
    check("read5_valid", 32'(bus.read_valid_o), 32'd0);
    srch("miss0", 32'h0, 1'b0, 5'd0, 1'b0);
    tick;
    check("pulse_one_cycle", 32'(bus.search_valid_o), 32'd0);
    wr(5'd3, 32'hDEADBEEF);
    wr(5'd7, 32'hDEADBEEF);
    check("free_after_wr", 32'(bus.free_index_o), 32'd0);
    srch("dup", 32'hDEADBEEF, 1'b1, 5'd3, 1'b1);
    inv(5'd3);
    srch("after_inv", 32'hDEADBEEF, 1'b1, 5'd7, 1'b0);
    bus.read_index_i = 5'd3;
    tick;
    check("read3_valid", 32'(bus.read_valid_o), 32'd0);
    check("read3_data_kept", bus.read_value_o, 32'hDEADBEEF);
    bus.write_enable_i  = 1'b1;
    bus.write_index_i   = 5'd9;
    bus.write_data_i    = 32'hA5A5A5A5;
    bus.search_enable_i = 1'b1;
    bus.search_data_i   = 32'hA5A5A5A5;
    tick;
    idle;
    tick;
    check("same_cycle_valid", 32'(bus.search_valid_o), 32'd1);
    check("same_cycle_hit", 32'(bus.search_hit_o), 32'd0);
    srch("next_cycle", 32'hA5A5A5A5, 1'b1, 5'd9, 1'b0);
    wr(5'd1, 32'h11);
    wr(5'd2, 32'h22);
    wr(5'd4, 32'h44);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        bus.search_enable_i = 1'b1;
        bus.search_data_i   = bb_key[i];
      end else bus.search_enable_i = 1'b0;
      tick;
      if (i == 0) check("b2b_latency", 32'(bus.search_valid_o), 32'd0);
      else begin
        check($sformatf("b2b%0d_valid", i - 1), 32'(bus.search_valid_o), 32'd1);
        check($sformatf("b2b%0d_hit", i - 1), 32'(bus.search_hit_o), 32'(bb_hit[i-1]));
        check($sformatf("b2b%0d_index", i - 1), 32'(bus.search_index_o), 32'(bb_idx[i-1]));
      end
    end
    for (int i = 0; i < 32; i++) wr(5'(i), 32'h1000 + 32'(i));
    check("full_free_valid", 32'(bus.free_valid_o), 32'd0);
    inv(5'd17);
    check("inv17_free_valid", 32'(bus.free_valid_o), 32'd1);
    check("inv17_free_index", 32'(bus.free_index_o), 32'd17);
    bus.write_enable_i     = 1'b1;
    bus.write_index_i      = 5'd17;
    bus.write_data_i       = 32'hCAFE0011;
    bus.invalidate_i       = 1'b1;
    bus.invalidate_index_i = 5'd17;
    tick;
    idle;
    check("wr_wins_free", 32'(bus.free_valid_o), 32'd0);
    bus.read_index_i = 5'd17;
    tick;
    check("wr_wins_valid", 32'(bus.read_valid_o), 32'd1);
    check("wr_wins_data", bus.read_value_o, 32'hCAFE0011);
    bus.write_enable_i     = 1'b1;
    bus.write_index_i      = 5'd20;
    bus.write_data_i       = 32'hBEEF0020;
    bus.invalidate_i       = 1'b1;
    bus.invalidate_index_i = 5'd18;
    tick;
    idle;
    check("both_free_index", 32'(bus.free_index_o), 32'd18);
    bus.read_index_i = 5'd20;
    tick;
    check("both_read_valid", 32'(bus.read_valid_o), 32'd1);
    check("both_read_data", bus.read_value_o, 32'hBEEF0020);
    wr(5'd5, 32'h12345678);
    srch("exact", 32'h12345678, 1'b1, 5'd5, 1'b0);
`ifdef CAM_TERNARY_EN
    bus.search_mask_i = 32'h000000FF;
    srch("tern_mask", 32'h123456FF, 1'b1, 5'd5, 1'b0);
    bus.search_mask_i = 32'h0;
    srch("tern_nomask", 32'h123456FF, 1'b0, 5'd0, 1'b0);
`endif
    bus.search_enable_i = 1'b1;
    bus.search_data_i   = 32'h12345678;
    tick;
    idle;
    #1 rst_i = 1'b0;
    #1 check("midrst_valid", 32'(bus.search_valid_o), 32'd0);
    #1 rst_i = 1'b1;
    tick;
    check("midrst_drop1", 32'(bus.search_valid_o), 32'd0);
    tick;
    check("midrst_drop2", 32'(bus.search_valid_o), 32'd0);
    check("midrst_free_valid", 32'(bus.free_valid_o), 32'd1);
    check("midrst_free_index", 32'(bus.free_index_o), 32'd0);
    check("midrst_read_valid", 32'(bus.read_valid_o), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/param_cam.md
Name: param_cam

Overview:
- Parametrised successor to the fixed 32x32 CAM: DEPTH entries of WIDTH bits, each with a valid bit.
- Adds a pipelined search with hit, first-index and multi-hit results, entry invalidation, registered read, and a free-entry allocator output.
- Sits beside the existing CAM in the lookup path and serves as the generic table for tag/ID lookups.

Parameters:
DEPTH, 32, number of entries; power of 2, at least 2
WIDTH, 32, entry and search-key width in bits
IDX_W, $clog2(DEPTH), index width; derived, never overridden

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous active-low reset
write_enable_i  in  1  write write_data_i into entry write_index_i and set its valid bit
write_index_i  in  IDX_W  write target
write_data_i  in  WIDTH  write data
invalidate_i  in  1  clear valid bit of entry invalidate_index_i
invalidate_index_i  in  IDX_W  invalidate target
read_index_i  in  IDX_W  read address, sampled every cycle
read_value_o  out  WIDTH  registered data of entry read_index_i
read_valid_o  out  1  registered valid bit of entry read_index_i
search_enable_i  in  1  issue one search this cycle
search_data_i  in  WIDTH  search key
search_valid_o  out  1  search result valid, exactly 2 cycles after issue
search_hit_o  out  1  at least one valid entry matched
search_index_o  out  IDX_W  lowest matching index; 0 when no hit
search_multi_o  out  1  two or more valid entries matched
free_valid_o  out  1  at least one entry is invalid
free_index_o  out  IDX_W  lowest invalid index; 0 when full

Behaviour:
- Reset (rst_i low, asynchronous): all valid bits 0, both pipeline stages invalid. All outputs 0 except free_valid_o=1 and free_index_o=0. Data storage is not reset.
- Write: entry data and valid bit update at the clock edge. A search, read or free lookup in the same cycle sees the old contents; from the next cycle the new contents are visible.
- Invalidate: clears the valid bit at the edge; data is retained. If write and invalidate target the same index in the same cycle, the write wins (valid=1). Different indices: both take effect.
- Read: 1-cycle latency. read_value_o and read_valid_o reflect the state before any same-edge write. Invalid entries still return their stored data with read_valid_o=0.
- Search pipeline, no backpressure, one search accepted per cycle (back-to-back supported):
  - S1 (issue edge): register the match vector. match[k] = valid[k] && (data[k] == key).
  - S2 (next edge): priority encode to the lowest set bit. search_hit_o = OR of matches. search_multi_o = more than one match. Register all results and assert search_valid_o for exactly one cycle.
  - When search_valid_o=0, all search outputs are forced to 0.
- Match uses the entry contents at the issue cycle. A write one cycle after issue does not affect that result.
- free_index_o / free_valid_o: combinational from the current valid vector (priority encode of ~valid). Free_index_o is intended to feed write_index_i directly.
- Reset asserted mid-search drops all in-flight results. No search_valid_o follows for searches issued before reset.
- Out-of-range indices cannot occur because DEPTH is a power of 2.

Optional Feature:
- Macro: CAM_TERNARY_EN.
- Defined: adds input port search_mask_i [WIDTH]. A 1 bit means don't care, so match[k] = valid[k] && ((data[k] ^ key) & ~mask) == 0. The mask is registered with the key in S1.
- Undefined: no port; exact match only.
- With mask all 0s, behaviour is identical to the undefined build.

Decomposition:
- Package cam_pkg: function clog2-based index width, the S1-to-S2 pipeline struct (valid, match vector), and a search result struct (hit, multi, index).
- One sub-module: cam_prio_enc, parametrised by N. Inputs: N-bit vector. Outputs: lowest set index, any-set, more-than-one-set.
- Instantiated twice: once on the match vector, once on ~valid for the free entry.

Test Plan (DEPTH=32, WIDTH=32):
- Reset, then read index 5 -> read_valid_o=0, free_valid_o=1, free_index_o=0. Search 0x0 -> 2 cycles later search_valid_o=1, hit=0, index=0.
- Write 0xDEADBEEF to 3 and 7, then search 0xDEADBEEF -> hit=1, index=3, multi=1. Invalidate 3, search again -> index=7, multi=0.
- Write 0xA5A5A5A5 to 9 and search the same key in the same cycle -> hit=0. Repeat the search next cycle -> hit=1, index=9.
- Back-to-back searches on 4 consecutive cycles with keys for entries 1, 2, missing, 4 -> 4 consecutive search_valid_o pulses returning indices 1, 2, miss, 4 in order.
- Write all 32 entries -> free_valid_o=0. Invalidate 17 -> free_index_o=17 next cycle. Write and invalidate 17 in the same cycle -> entry valid.
- CAM_TERNARY_EN: entry 0x12345678, key 0x123456FF, mask 0x000000FF -> hit=1, index of that entry. Mask 0 -> hit=0. Reset pulsed mid-search -> no search_valid_o.
